// File: rtl/shift_fifo_pkg.sv
// Shared constants and helpers for the shift-register FIFO.
package shift_fifo_pkg;

   localparam int MODE_RAW       = 0;
   localparam int MODE_HANDSHAKE = 1;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/shift_register_fifo_v2_if.sv
// Push/pop handshake bundle; master is the environment, slave is the FIFO.
interface shift_register_fifo_v2_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/FF.sv
// Enabled register cell with active-high async reset to INIT.
module FF #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= INIT;
      else if (en) q <= d;
   end

endmodule

// File: rtl/shift_register_fifo_v2.sv
// First-word-fall-through shift FIFO, head at entry 0; pushes visible after 1 cycle.
// MODE 1 backpressures via in_ready; MODE 0 always ready, drops illegal ops and flags them.
module shift_register_fifo_v2
   import shift_fifo_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 8,
   parameter int MODE       = 1,
   parameter int AFULL_LVL  = DEPTH - 1,
   parameter int AEMPTY_LVL = 1,
   parameter int CNTWID     = cnt_width(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   shift_register_fifo_v2_if.slave bus,
   output logic [CNTWID-1:0]    count,
   output logic                 empty,
   output logic                 full,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 overflow,
   output logic                 underflow
);

   localparam bit               HS       = (MODE == MODE_HANDSHAKE);
   localparam logic [CNTWID-1:0] DEPTH_C  = CNTWID'(DEPTH);
   localparam logic [CNTWID-1:0] AFULL_C  = CNTWID'(AFULL_LVL);
   localparam logic [CNTWID-1:0] AEMPTY_C = CNTWID'(AEMPTY_LVL);

   logic [WIDTH-1:0]  entry [DEPTH];
   logic              push;
   logic              pop;
   logic [CNTWID-1:0] wr_idx;

   assign empty        = (count == '0);
   assign full         = (count == DEPTH_C);
   assign almost_full  = (count >= AFULL_C);
   assign almost_empty = (count <= AEMPTY_C);

   assign pop    = bus.out_ready & ~empty;
   assign push   = HS ? (bus.in_valid & ~full) : (bus.in_valid & (~full | pop));
   assign wr_idx = count - CNTWID'(pop);

   assign bus.in_ready  = HS ? ~full : 1'b1;
   assign bus.out_valid = ~empty;
   assign bus.out_data  = entry[0];

   // Each slot either takes new data, shifts toward the head, or is cleared.
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [WIDTH-1:0] shift_src;
      logic [WIDTH-1:0] nxt;
      logic             en;

      if (i < DEPTH - 1) begin : g_mid
         assign shift_src = entry[i+1];
      end else begin : g_last
         assign shift_src = '0;
      end

      always_comb begin
         nxt = entry[i];
         if (clr)                                   nxt = '0;
         else if (push && (wr_idx == CNTWID'(i)))   nxt = bus.in_data;
         else if (pop)                              nxt = shift_src;
      end

      assign en = pop | (push & (count == CNTWID'(i))) | clr;

      FF #(.WIDTH(WIDTH), .INIT('0)) u_ff (
         .clk (clk),
         .rst (~rst_n),
         .en  (en),
         .d   (nxt),
         .q   (entry[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         count     <= count + CNTWID'(push) - CNTWID'(pop);
         overflow  <= overflow | (!HS && bus.in_valid && full && !bus.out_ready);
         underflow <= underflow | (bus.out_ready && empty);
      end
   end

endmodule

// File: tb/tb_shift_register_fifo_v2.sv
// Drives a MODE 0 and a MODE 1 FIFO (DEPTH=4, WIDTH=8) with shared stimulus against a queue model.
module tb_shift_register_fifo_v2;

   localparam int D = 4;
   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         clr;
   logic         iv;
   logic [W-1:0] id;
   logic         ordy;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state: contents as plain queues, sticky flags as bits.
   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];
   bit           ovf[2];
   bit           unf[2];

   shift_register_fifo_v2_if #(.WIDTH(W)) if_raw ();
   shift_register_fifo_v2_if #(.WIDTH(W)) if_hs ();

   logic [2:0] cnt_raw, cnt_hs;
   logic e_raw, f_raw, af_raw, ae_raw, of_raw, uf_raw;
   logic e_hs,  f_hs,  af_hs,  ae_hs,  of_hs,  uf_hs;

   assign if_raw.in_valid  = iv;
   assign if_raw.in_data   = id;
   assign if_raw.out_ready = ordy;
   assign if_hs.in_valid   = iv;
   assign if_hs.in_data    = id;
   assign if_hs.out_ready  = ordy;

   shift_register_fifo_v2 #(.WIDTH(W), .DEPTH(D), .MODE(0), .AFULL_LVL(3), .AEMPTY_LVL(1)) u_raw (
      .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_raw.slave),
      .count(cnt_raw), .empty(e_raw), .full(f_raw), .almost_full(af_raw),
      .almost_empty(ae_raw), .overflow(of_raw), .underflow(uf_raw)
   );

   shift_register_fifo_v2 #(.WIDTH(W), .DEPTH(D), .MODE(1), .AFULL_LVL(3), .AEMPTY_LVL(1)) u_hs (
      .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_hs.slave),
      .count(cnt_hs), .empty(e_hs), .full(f_hs), .almost_full(af_hs),
      .almost_empty(ae_hs), .overflow(of_hs), .underflow(uf_hs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      ovf = '{0, 0};
      unf = '{0, 0};
   endtask

   // One clock edge of the reference behaviour for both modes.
   task automatic model_edge();
      int  sz;
      bit  p_pop, p_push;
      if (clr) begin
         model_reset();
         return;
      end
      for (int m = 0; m < 2; m++) begin
         sz     = (m == 0) ? q0.size() : q1.size();
         p_pop  = ordy && (sz > 0);
         p_push = (m == 1) ? (iv && sz < D) : (iv && (sz < D || p_pop));
         if (ordy && sz == 0)               unf[m] = 1;
         if (m == 0 && iv && sz == D && !ordy) ovf[m] = 1;
         if (m == 0) begin
            if (p_pop)  void'(q0.pop_front());
            if (p_push) q0.push_back(id);
         end else begin
            if (p_pop)  void'(q1.pop_front());
            if (p_push) q1.push_back(id);
         end
      end
   endtask

   task automatic chk_one(input string p, input int m, input logic [2:0] cnt,
                          input logic [W-1:0] od, input logic ov, input logic ir,
                          input logic e, input logic f, input logic af, input logic ae,
                          input logic of, input logic uf);
      int           sz;
      logic [W-1:0] head;
      sz   = (m == 0) ? q0.size() : q1.size();
      head = (sz == 0) ? '0 : ((m == 0) ? q0[0] : q1[0]);
      chk({p, ".count"},        32'(cnt), 32'(sz));
      chk({p, ".out_data"},     32'(od),  32'(head));
      chk({p, ".out_valid"},    32'(ov),  32'(sz > 0));
      chk({p, ".in_ready"},     32'(ir),  (m == 1) ? 32'(sz < D) : 32'd1);
      chk({p, ".empty"},        32'(e),   32'(sz == 0));
      chk({p, ".full"},         32'(f),   32'(sz == D));
      chk({p, ".almost_full"},  32'(af),  32'(sz >= 3));
      chk({p, ".almost_empty"}, 32'(ae),  32'(sz <= 1));
      chk({p, ".overflow"},     32'(of),  32'(ovf[m]));
      chk({p, ".underflow"},    32'(uf),  32'(unf[m]));
   endtask

   task automatic check_all();
      chk_one("raw", 0, cnt_raw, if_raw.out_data, if_raw.out_valid, if_raw.in_ready,
              e_raw, f_raw, af_raw, ae_raw, of_raw, uf_raw);
      chk_one("hs", 1, cnt_hs, if_hs.out_data, if_hs.out_valid, if_hs.in_ready,
              e_hs, f_hs, af_hs, ae_hs, of_hs, uf_hs);
   endtask

   task automatic step(input logic c, input logic v, input logic [W-1:0] d, input logic r);
      clr  = c;
      iv   = v;
      id   = d;
      ordy = r;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      rst_n = 1'b0;
      clr   = 1'b0;
      iv    = 1'b0;
      id    = '0;
      ordy  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      #2 rst_n = 1'b1;

      // Fill and drain, including a push attempt while full and a pop while empty.
      step(0, 1, 8'h11, 0);
      step(0, 1, 8'h22, 0);
      step(0, 1, 8'h33, 0);
      step(0, 1, 8'h44, 0);
      step(0, 1, 8'h55, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);
      step(1, 0, 8'h00, 0);

      // Simultaneous push and pop while full, then drain to expose the tail entry.
      for (int i = 0; i < 4; i++) step(0, 1, 8'hA0 + 8'(i), 0);
      step(0, 1, 8'hB0, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);

      // Push and pop together on an empty FIFO: push wins, pop flags underflow.
      step(1, 0, 8'h00, 0);
      step(0, 1, 8'h5A, 1);
      step(0, 0, 8'h00, 0);

      // clr with a push pending discards the push.
      step(1, 1, 8'hEE, 1);

      // Asynchronous reset between edges at count 3.
      step(0, 1, 8'h01, 0);
      step(0, 1, 8'h02, 0);
      step(0, 1, 8'h03, 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #2 rst_n = 1'b1;
      step(0, 1, 8'h7E, 0);
      step(0, 0, 8'h00, 0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 6),
              8'($urandom), ($urandom_range(0, 9) < 5));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_register_fifo_v2.md
# shift_register_fifo_v2

Parametrised shift-register FIFO for the datapath. It holds up to DEPTH words of WIDTH bits, with the head entry always at position 0 and entries shifting toward the head on every pop. It adds a valid/ready handshake mode, programmable almost-full and almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags, so callers no longer depend on environment constraints. It sits between producer and consumer stages wherever a shallow, first-word-fall-through buffer is needed.

## Interface
- WIDTH, 8: data width in bits (≥1).
- DEPTH, 8: number of entries (≥2).
- MODE, 1: 1 = handshake (ready gates pushes; overflow impossible). 0 = raw push/pop (illegal operations are dropped and flagged).
- AFULL_LVL, DEPTH-1: almost_full asserts when count ≥ AFULL_LVL.
- AEMPTY_LVL, 1: almost_empty asserts when count ≤ AEMPTY_LVL.
- CNTWID, $clog2(DEPTH+1): derived; do not override.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush; clears count, entries and error flags.
- in_valid  in  1  push request.
- in_data  in  WIDTH  push data.
- in_ready  out  1  equals ~full in MODE 1; tied to 1 in MODE 0.
- out_valid  out  1  equals ~empty.
- out_ready  in  1  pop request.
- out_data  out  WIDTH  head entry (entries[0]); 0 when empty.
- count  out  CNTWID  current occupancy, 0..DEPTH.
- empty, full, almost_full, almost_empty  out  1 each  status flags, all decoded from count.
- overflow, underflow  out  1 each  sticky error flags; always 0 in MODE 1 for overflow.

## Operation
- Reset values (asynchronous, while rst_n=0): count=0, all entries 0, overflow=underflow=0. As a result, empty=1, almost_empty=1, out_valid=0, out_data=0, and in_ready=1.
- Accepted pop: pop = out_ready & ~empty.
- Accepted push:
  - MODE 1: push = in_valid & ~full.
  - MODE 0: push = in_valid & (~full | pop).
- Shift on pop: entries[i] ← entries[i+1] for i < DEPTH-1, and entries[DEPTH-1] ← 0.
- Write location on push: in_data is written at index count−pop. This means it goes to index count without a pop, and to count−1 with a simultaneous pop.
- Count update: count ← count + push − pop. Computed at CNTWID bits; it never wraps, because push and pop are legalised first.
- Full with push and pop together: both are accepted in MODE 0. In MODE 1 only the pop is accepted, because in_ready=0.
- Empty with push and pop together: the pop is rejected (no bypass) and the push is accepted.
- Error flags, MODE 0 only:
  - overflow ← 1 on in_valid & full & ~out_ready.
  - underflow ← 1 on out_ready & empty.
  - Both flags hold until clr or reset.
- Underflow in MODE 1: underflow is still flagged on out_ready & empty. Overflow stays 0 in MODE 1.
- clr has priority over push and pop. On clr, any push or pop in that cycle is discarded, and the next state equals the reset state.
- Unused entries (index ≥ count) are always 0.

## Timing
- Push-to-visible latency is 1 cycle. A word pushed into an empty FIFO appears on out_data, with out_valid=1, after the next rising edge.
- Pop is effective at the edge. The next word is on out_data in the following cycle.
- All outputs are functions of registered state only. There is no combinational path from in_valid or out_ready to any output.
- Deasserting rst_n mid-operation clears state immediately, with no clock required. Release of rst_n is synchronised externally.

## Structure
- Package shift_fifo_pkg holds:
  - mode constants MODE_RAW=0 and MODE_HANDSHAKE=1;
  - a function cnt_width(depth) returning $clog2(depth+1).
- Per-entry storage uses the existing enabled register cell FF (WIDTH, INIT=0), with async reset wired to ~rst_n.
- The enable for entry i is: pop | (push & count==i) | clr.
- The next-value mux for each entry is generated; there are no other sub-modules.

## Test plan
All scenarios use DEPTH=4, WIDTH=8.
- **Fill and drain, MODE 1.** Push 0x11, 0x22, 0x33, 0x44, then attempt a push of 0x55 → full=1, in_ready=0, and 0x55 is ignored. Pop 4 times → out_data reads 0x11, 0x22, 0x33, 0x44, then empty=1 and out_data=0.
- **Simultaneous push/pop at full, MODE 0.** Start with count=4 holding 0xA0..0xA3. Push 0xB0 together with a pop → count=4, head=0xA1, entries[3]=0xB0, overflow=0.
- **Error flags, MODE 0.** Push while full without a pop → overflow=1 and the data is unchanged. Pop while empty → underflow=1 and count=0. Both flags stay set until clr, after which both are 0.
- **Empty with push and pop together.** From count=0, push 0x5A together with a pop → count=1, out_data=0x5A on the next cycle, underflow=1 (MODE 0).
- **Thresholds.** With AFULL_LVL=3 and AEMPTY_LVL=1: at count 0..4, almost_full reads 0,0,0,1,1 and almost_empty reads 1,1,0,0,0.
- **Async reset mid-stream.** At count=3, drive rst_n low between clock edges → count=0, out_data=0, flags cleared immediately. After release, a push of 0x7E is visible on the next cycle.
